riscv_v_rf_mp: RTL and testbench
================================

Name: riscv_v_rf_mp

Overview:
Parametrised multi-port RISC-V vector register file. It succeeds the single-write/dual-read vector RF.
- Read port count and vector length are configurable.
- Writes use byte enables, for tail/mask-undisturbed element updates.
- Same-cycle write-to-read bypass is configurable.
- A dedicated mask output tracks the mask register.
- A soft-clear sequencer zeroes the array one register per cycle.
Sits between the vector decode/issue stage and the vector execution lanes.

Parameters:
NUM_REGS, 32, number of vector registers (power of 2, >=2)
VLEN, 128, register width in bits (multiple of 8)
NUM_RD_PORTS, 3, number of independent read ports (>=1)
BYPASS, 1, 1 = same-cycle write forwarded to reads, 0 = reads see pre-write contents
MASK_REG, 0, index of register driven on mask output
AW (localparam), $clog2(NUM_REGS)
BW (localparam), VLEN/8

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
wr_en  input  1  write request
wr_addr  input  AW  write register index
wr_be  input  BW  byte write enables, bit i covers wr_data[8i+7:8i]
wr_data  input  VLEN  write data
rd_en  input  NUM_RD_PORTS  per-port read request
rd_addr  input  NUM_RD_PORTS x AW  per-port read index (packed array)
rd_data  output  NUM_RD_PORTS x VLEN  per-port read data
rd_valid  output  NUM_RD_PORTS  per-port read data valid
mask  output  VLEN  contents of register MASK_REG
clr_req  input  1  start soft clear of whole array
clr_busy  output  1  soft clear in progress

Behaviour:
- Reset (rst=1 at posedge):
  - All NUM_REGS registers become 0.
  - rd_data=0, rd_valid=0, mask=0, clr_busy=0.
  - FSM returns to IDLE and the clear counter goes to 0.
  - Reset overrides any write, read or clear in flight, including mid-clear.
- Write:
  - At the posedge with wr_en=1 and clr_busy=0, each byte i with wr_be[i]=1 of reg[wr_addr] takes wr_data byte i.
  - Bytes with wr_be[i]=0 are unchanged. wr_be=0 is a no-op.
- Read:
  - Latency is 1 cycle. rd_en[p] at edge N gives rd_valid[p]=1 and rd_data[p] valid after edge N.
  - When rd_en[p]=0, rd_valid[p]=0 and rd_data[p] holds its last value.
  - All ports are independent. Any number of ports may read the same address in one cycle.
- Bypass, for a write and a read to the same address in the same cycle:
  - BYPASS=1: rd_data gets the merged value, i.e. the new bytes where wr_be=1 and the old bytes elsewhere.
  - BYPASS=0: rd_data gets the pre-write contents.
- Mask:
  - mask is a registered mirror of reg[MASK_REG].
  - A write to MASK_REG at edge N is visible on mask after edge N, with byte enables honoured.
  - A soft clear drives mask to 0 when MASK_REG is cleared.
- Soft-clear FSM:
  - States are IDLE and CLEAR. The counter clr_idx is AW bits wide.
  - IDLE -> CLEAR on clr_req=1. clr_busy=1 from the next cycle, clr_idx=0.
  - In CLEAR, each cycle: reg[clr_idx]=0, then clr_idx++.
  - CLEAR -> IDLE after clearing index NUM_REGS-1, so exactly NUM_REGS cycles with clr_busy=1. clr_idx wraps to 0.
  - clr_req while in CLEAR is ignored and does not restart the sequence.
  - Writes while clr_busy=1 are dropped silently.
  - Reads while clr_busy=1 are serviced normally and return the current contents, either cleared or not yet cleared. No bypass applies to clear zeroing.
  - A write in the same cycle as clr_req (FSM in IDLE) is performed. The clear then zeroes that register in its turn.
- Out-of-range addresses cannot occur because NUM_REGS is a power of 2.

Test Plan:
- Reset then read: rst 1 cycle, then rd_en=3'b111 with rd_addr={5,1,0} -> next cycle rd_valid=3'b111, all rd_data=0, mask=0, clr_busy=0.
- Byte-enable write: write reg3 = 0xFF..FF with wr_be all ones, then write 0x0 with wr_be=0x000F, read reg3 -> low 4 bytes 0x00, upper 12 bytes 0xFF.
- Bypass: reg7 = 0xAA..AA, same cycle write 0x55..55 with wr_be=0x00FF and read reg7 on ports 0,1,2 -> BYPASS=1: low 8 bytes 0x55, high 8 bytes 0xAA on all ports. BYPASS=0: all bytes 0xAA.
- Mask tracking: write reg0 = 0x1234 (full be) at edge N -> mask=0x...1234 after edge N. Write to reg1 -> mask unchanged.
- Soft clear: fill all 32 regs with nonzero data, pulse clr_req, then assert clr_req again at cycle 5 and attempt a write at cycle 10 -> clr_busy high exactly 32 cycles, second clr_req ignored, write dropped, all regs read 0 afterwards.
- Reset mid-clear: clr_req, then rst at clr cycle 12 -> next cycle clr_busy=0, FSM IDLE, all regs 0. A new write succeeds immediately.

Source files
------------

// File: rtl/riscv_v_rf_mp.sv
// Multi-port vector register file: byte-enable writes, optional write-to-read bypass,
// mirrored mask register and a one-register-per-cycle soft-clear sequencer.
module riscv_v_rf_mp #(
    parameter  int unsigned NUM_REGS     = 32,
    parameter  int unsigned VLEN         = 128,
    parameter  int unsigned NUM_RD_PORTS = 3,
    parameter  int unsigned BYPASS       = 1,
    parameter  int unsigned MASK_REG     = 0,
    localparam int unsigned AW           = $clog2(NUM_REGS),
    localparam int unsigned BW           = VLEN / 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wr_en,
    input  logic [AW-1:0]                          wr_addr,
    input  logic [BW-1:0]                          wr_be,
    input  logic [VLEN-1:0]                        wr_data,
    input  logic [NUM_RD_PORTS-1:0]                rd_en,
    input  logic [NUM_RD_PORTS-1:0][AW-1:0]        rd_addr,
    output logic [NUM_RD_PORTS-1:0][VLEN-1:0]      rd_data,
    output logic [NUM_RD_PORTS-1:0]                rd_valid,
    output logic [VLEN-1:0]                        mask,
    input  logic                                   clr_req,
    output logic                                   clr_busy
);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    localparam logic [AW-1:0] MASK_IDX = AW'(MASK_REG);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    state_t                              r_state;
    state_t                              w_state_nxt;
    logic [AW-1:0]                       r_clr_idx;
    logic [VLEN-1:0]                     r_mem [NUM_REGS];
    logic                                w_wr_fire;
    logic                                w_clr_fire;
    logic [VLEN-1:0]                     w_wr_merged;
    logic [NUM_RD_PORTS-1:0][VLEN-1:0]   w_rd_word;

    assign clr_busy  = (r_state == ST_CLEAR);
    assign w_wr_fire = wr_en && !clr_busy;

    // Old contents with the enabled bytes replaced; feeds both the array and the bypass path.
    always_comb begin
        w_wr_merged = r_mem[wr_addr];
        for (int unsigned b = 0; b < BW; b++) begin
            if (wr_be[b]) begin
                w_wr_merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr_fire  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_clr_fire = 1'b1;
                if (r_clr_idx == LAST_IDX) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clr_fire) begin
                r_clr_idx <= r_clr_idx + 1'b1;
            end
        end
    end

    // Writes and clear zeroing never coincide: writes are blocked while clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_fire) begin
                r_mem[wr_addr] <= w_wr_merged;
            end
            if (w_clr_fire) begin
                r_mem[r_clr_idx] <= '0;
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
            if ((BYPASS != 0) && w_wr_fire && (wr_addr == rd_addr[p])) begin
                w_rd_word[p] = w_wr_merged;
            end else begin
                w_rd_word[p] = r_mem[rd_addr[p]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            rd_valid <= rd_en;
            for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
                if (rd_en[p]) begin
                    rd_data[p] <= w_rd_word[p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '0;
        end else if (w_clr_fire && (r_clr_idx == MASK_IDX)) begin
            mask <= '0;
        end else if (w_wr_fire && (wr_addr == MASK_IDX)) begin
            mask <= w_wr_merged;
        end
    end

endmodule

// File: tb/tb_riscv_v_rf_mp.sv
// Directed bench for riscv_v_rf_mp at default parameters (32 x 128b, 3 read ports, bypass on, mask reg 0).
module tb_riscv_v_rf_mp;

    localparam int unsigned AW = 5;
    localparam int unsigned VL = 128;

    logic                 clk;
    logic                 rst;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [15:0]          wr_be;
    logic [VL-1:0]        wr_data;
    logic [2:0]           rd_en;
    logic [2:0][AW-1:0]   rd_addr;
    logic [2:0][VL-1:0]   rd_data;
    logic [2:0]           rd_valid;
    logic [VL-1:0]        mask;
    logic                 clr_req;
    logic                 clr_busy;

    int n_pass = 0;
    int n_chk  = 0;
    int cnt;

    riscv_v_rf_mp #(
        .NUM_REGS(32),
        .VLEN(128),
        .NUM_RD_PORTS(3),
        .BYPASS(1),
        .MASK_REG(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_be(wr_be),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .mask(mask),
        .clr_req(clr_req),
        .clr_busy(clr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [VL-1:0] obs, input logic [VL-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [VL-1:0] fill(input int unsigned i);
        logic [7:0] b;
        b = 8'(i + 1);
        return {16{b}};
    endfunction

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
        rd_en = '0; rd_addr = '0; clr_req = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_valid", VL'(rd_valid), '0);
        check("rst_busy", VL'(clr_busy), '0);

        rd_en = 3'b111; rd_addr[2] = 5'd5; rd_addr[1] = 5'd1; rd_addr[0] = 5'd0;
        tick();
        rd_en = '0;
        check("rst_rd_valid", VL'(rd_valid), VL'(3'b111));
        check("rst_rd0", rd_data[0], '0);
        check("rst_rd1", rd_data[1], '0);
        check("rst_rd2", rd_data[2], '0);
        check("rst_mask", mask, '0);

        // Byte-enable write to reg3
        wr_en = 1'b1; wr_addr = 5'd3; wr_be = 16'hFFFF; wr_data = '1;
        tick();
        wr_be = 16'h000F; wr_data = '0;
        tick();
        wr_be = 16'h0000; wr_data = '0;
        tick();
        wr_en = 1'b0;
        rd_en = 3'b001; rd_addr[0] = 5'd3;
        tick();
        rd_en = '0;
        check("be_rd_valid", VL'(rd_valid), VL'(3'b001));
        check("be_reg3", rd_data[0], {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0});
        tick();
        check("hold_valid", VL'(rd_valid), '0);
        check("hold_data", rd_data[0], {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0});

        // Same-cycle write/read bypass on reg7
        wr_en = 1'b1; wr_addr = 5'd7; wr_be = 16'hFFFF; wr_data = {16{8'hAA}};
        tick();
        wr_be = 16'h00FF; wr_data = {16{8'h55}};
        rd_en = 3'b111; rd_addr[0] = 5'd7; rd_addr[1] = 5'd7; rd_addr[2] = 5'd7;
        tick();
        wr_en = 1'b0;
        check("byp_p0", rd_data[0], {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555});
        check("byp_p1", rd_data[1], {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555});
        check("byp_p2", rd_data[2], {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555});
        rd_en = 3'b010; rd_addr[1] = 5'd3;
        tick();
        rd_en = '0;
        check("indep_p1", rd_data[1], {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0});
        check("indep_p0_hold", rd_data[0], {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555});

        // Mask tracking
        check("mask_pre", mask, '0);
        wr_en = 1'b1; wr_addr = 5'd0; wr_be = 16'hFFFF; wr_data = 128'h1234;
        tick();
        check("mask_wr", mask, 128'h1234);
        wr_addr = 5'd1; wr_data = {16{8'h77}};
        tick();
        check("mask_other", mask, 128'h1234);
        wr_addr = 5'd0; wr_be = 16'h0001; wr_data = '1;
        tick();
        wr_en = 1'b0;
        check("mask_be", mask, 128'h12FF);

        // Fill all registers, then soft clear
        wr_en = 1'b1; wr_be = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            wr_addr = AW'(i); wr_data = fill(i);
            tick();
        end
        wr_en = 1'b0;
        check("fill_mask", mask, fill(0));
        rd_en = 3'b001; rd_addr[0] = 5'd31;
        tick();
        rd_en = '0;
        check("fill_r31", rd_data[0], fill(31));

        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cnt = 0;
        while (clr_busy && cnt < 100) begin
            cnt++;
            clr_req = (cnt == 5);
            if (cnt == 10) begin
                wr_en = 1'b1; wr_addr = 5'd2; wr_be = 16'hFFFF; wr_data = {16{8'hEE}};
            end else begin
                wr_en = 1'b0;
            end
            if (cnt == 20) begin
                rd_en = 3'b011; rd_addr[0] = 5'd30; rd_addr[1] = 5'd5;
            end else begin
                rd_en = '0;
            end
            tick();
        end
        clr_req = 1'b0; wr_en = 1'b0; rd_en = '0;
        check("clr_cycles", VL'(cnt), VL'(32));
        check("clr_rd_uncleared", rd_data[0], fill(30));
        check("clr_rd_cleared", rd_data[1], '0);
        check("clr_mask", mask, '0);
        tick();
        check("clr_no_restart", VL'(clr_busy), '0);
        for (int i = 0; i < 32; i++) begin
            rd_en = 3'b001; rd_addr[0] = AW'(i);
            tick();
            check($sformatf("clr_reg%0d", i), rd_data[0], '0);
        end
        rd_en = '0;

        // Reset in the middle of a clear
        wr_en = 1'b1; wr_be = 16'hFFFF;
        wr_addr = 5'd20; wr_data = fill(20);
        tick();
        wr_addr = 5'd31; wr_data = fill(31);
        tick();
        wr_en = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        check("mid_busy", VL'(clr_busy), VL'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", VL'(clr_busy), '0);
        check("mid_rst_mask", mask, '0);
        wr_en = 1'b1; wr_addr = 5'd9; wr_be = 16'hFFFF; wr_data = 128'hDEAD;
        rd_en = 3'b011; rd_addr[0] = 5'd31; rd_addr[1] = 5'd20;
        tick();
        wr_en = 1'b0;
        check("mid_r31", rd_data[0], '0);
        check("mid_r20", rd_data[1], '0);
        check("mid_idle", VL'(clr_busy), '0);
        rd_en = 3'b100; rd_addr[2] = 5'd9;
        tick();
        rd_en = '0;
        check("post_rst_write", rd_data[2], 128'hDEAD);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
